// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcode, flag and state definitions for alu_sequencer
//
// Purpose: one-hot ALU opcode encodings, result-flag bit positions and the
// sequencer FSM state type. Imported by alu_sequencer and its testbench.
// Ports: none (package).

package alu_seq_pkg;

    localparam logic [6:0] OP_ADD = 7'b0000001;
    localparam logic [6:0] OP_SUB = 7'b0000010;
    localparam logic [6:0] OP_AND = 7'b0000100;
    localparam logic [6:0] OP_OR  = 7'b0001000;
    localparam logic [6:0] OP_NOT = 7'b0010000;
    localparam logic [6:0] OP_SHL = 7'b0100000;
    localparam logic [6:0] OP_SHR = 7'b1000000;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_POS   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_sequencer_rr_arbiter.sv
// rtl/alu_sequencer_rr_arbiter.sv - round-robin arbiter with combinational grant
//
// Purpose: grants the first requesting bit at or after the rotating pointer.
// The pointer moves to (granted index + 1) mod NREQ on the accept edge.
// Ports:
//   clk_i     clock
//   rst_ni    asynchronous active-low reset (pointer -> 0)
//   req_i     NREQ request bits
//   accept_i  grant consumed this cycle; advances the pointer
//   grant_o   one-hot grant (zero when no request)
//   idx_o     binary index of the granted requester

module rr_arbiter #(
    parameter int  NREQ = 2,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [NREQ-1:0] req_i,
    input  logic            accept_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic          found;
    int            cand;

    // Walk the requesters cyclically starting at the pointer; first hit wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        for (int off = 0; off < NREQ; off++) begin
            cand = int'(ptr_q) + off;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = IW'(cand);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept_i) begin
            ptr_d = (idx_o == IW'(NREQ - 1)) ? '0 : idx_o + IW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - sequences a shared registered 8-bit ALU for NREQ requesters
//
// Purpose: round-robin picks a requester, operands are latched, the ALU is
// loaded (LOAD), held for its latency (WAIT, oe in the last cycle), the result
// is captured (CAPTURE) and returned with a one-cycle one-hot resp_valid.
// Optional macro ALU_SEQ_CARRY_CHAIN_EN: per-requester stored carry, selected
// into alu_fi[0] when req_chain is set at accept.
// Ports:
//   clk, rst (async active-low)
//   req_valid/req_ready       per-requester handshake, ready is the one-hot grant
//   req_a/req_b/req_op/req_cin/req_chain  packed per-requester request fields
//   resp_valid/resp_data/resp_flags       completion pulse and held result
//   alu_a/alu_b/alu_fi/alu_op/alu_wa/alu_wb/alu_oe  ALU drive
//   alu_d/alu_fo              ALU result and flags

module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int ALU_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    input  logic [7*NREQ-1:0] req_op,
    input  logic [NREQ-1:0]   req_cin,
    input  logic [NREQ-1:0]   req_chain,
    output logic [NREQ-1:0]   resp_valid,
    output logic [7:0]        resp_data,
    output logic [7:0]        resp_flags,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [7:0]        alu_fi,
    output logic [6:0]        alu_op,
    output logic              alu_wa,
    output logic              alu_wb,
    output logic              alu_oe,
    input  logic [7:0]        alu_d,
    input  logic [7:0]        alu_fo
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(ALU_LAT) + 1;

    seq_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    a_q, b_q;
    logic [6:0]    op_q;
    logic          fi_q;
    logic [IW-1:0] idx_q;

    logic [NREQ-1:0] resp_valid_q;
    logic [7:0]      resp_data_q;
    logic [7:0]      resp_flags_q;

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic            accept;
    logic            fi_sel;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk_i    (clk),
        .rst_ni   (rst),
        .req_i    (req_valid & {NREQ{state_q == IDLE}}),
        .accept_i (accept),
        .grant_o  (grant),
        .idx_o    (grant_idx)
    );

    // Ready is forced low while reset is asserted so the grant never leaks out.
    assign req_ready = (state_q == IDLE && rst) ? grant : '0;
    assign accept    = |(req_valid & req_ready);

`ifdef ALU_SEQ_CARRY_CHAIN_EN
    logic [NREQ-1:0] carry_q;
    logic            unused_fo;

    assign fi_sel    = req_chain[grant_idx] ? carry_q[grant_idx] : req_cin[grant_idx];
    assign unused_fo = ^alu_fo[7:3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            carry_q <= '0;
        end else if (state_q == CAPTURE) begin
            carry_q[idx_q] <= alu_fo[FLAG_CARRY];
        end
    end
`else
    logic unused_in;

    assign fi_sel    = req_cin[grant_idx];
    // Chain select and the upper ALU flag bits have no consumer in this build.
    assign unused_in = ^{req_chain, alu_fo[7:3]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        alu_a   = '0;
        alu_b   = '0;
        alu_fi  = '0;
        alu_op  = '0;
        alu_wa  = 1'b0;
        alu_wb  = 1'b0;
        alu_oe  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                alu_wa  = 1'b1;
                alu_wb  = 1'b1;
                alu_a   = a_q;
                alu_b   = b_q;
                alu_op  = op_q;
                alu_fi  = {7'b0, fi_q};
                state_d = WAIT;
                cnt_d   = CW'(ALU_LAT - 1);
            end
            WAIT: begin
                // Operands stay on the bus: shift ops read the raw inputs.
                alu_a  = a_q;
                alu_b  = b_q;
                alu_op = op_q;
                alu_fi = {7'b0, fi_q};
                if (cnt_q == CW'(1)) begin
                    alu_oe  = 1'b1;
                    state_d = CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            CAPTURE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            fi_q         <= 1'b0;
            idx_q        <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                a_q   <= req_a[grant_idx*8 +: 8];
                b_q   <= req_b[grant_idx*8 +: 8];
                op_q  <= req_op[grant_idx*7 +: 7];
                fi_q  <= fi_sel;
                idx_q <= grant_idx;
            end
            resp_valid_q <= '0;
            if (state_q == CAPTURE) begin
                resp_valid_q <= NREQ'(1) << idx_q;
                resp_data_q  <= alu_d;
                resp_flags_q <= {5'b0, alu_fo[FLAG_POS], alu_fo[FLAG_ZERO], alu_fo[FLAG_CARRY]};
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_flags = resp_flags_q;

endmodule
